// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types, constants and helpers for the BCD down-counter
//                slice (digit type, FSM state type, digit saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Largest legal value of a single BCD digit.
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Clamp an illegal digit code (0xA..0xF) to 9 so the count stays legal BCD.
  function automatic bcd_digit_t bcd_sat(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_digit
//  Description : Combinational single-digit BCD decrementer. With borrow_in
//                the digit decrements; a 0 wraps to 9 and raises borrow_out.
//                Without borrow_in the digit passes through unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t next_digit,
  output logic       borrow_out
);

  // Decrement one digit when a borrow arrives, wrapping 0 -> 9 with borrow out.
  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_counter
//  Description : Cascaded DIGITS-digit BCD countdown timer. start loads a
//                sanitised BCD preset; each enabled cycle in RUN decrements
//                by one with digit-to-digit borrow; reaching zero emits a
//                one-cycle done pulse and returns to IDLE.
//                Build option BCD_DOWN_COUNTER_AUTO_RELOAD_EN: on terminal
//                count the last started preset is reloaded and the counter
//                stays in RUN (periodic tick).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  zero,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           zero_q,  zero_d;
  logic           done_q,  done_d;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0]   reload_q, reload_d;
`endif

  logic [W-1:0]   load_sat;   // preset with every digit clamped to 0..9
  logic [W-1:0]   count_dec;  // count_q minus one, in BCD
  logic [DIGITS:0] borrow;    // borrow chain; borrow[0] is the "minus one"

  assign borrow[0] = 1'b1;

  // Per-digit preset sanitising and the decrement borrow chain.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign load_sat[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);

      bcd_down_digit u_digit (
        .digit      (count_q[4*i +: 4]),
        .borrow_in  (borrow[i]),
        .next_digit (count_dec[4*i +: 4]),
        .borrow_out (borrow[i+1])
      );
    end
  endgenerate

  // Next-state, next-count and flag logic; abort dominates start dominates en.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (abort) begin
      // Abort freezes the count; outside RUN it changes nothing (and it
      // also suppresses a simultaneous start).
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (start) begin
      count_d = load_sat;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = load_sat;
`endif
      if (load_sat == '0) begin
        // A zero preset is already at terminal count.
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) && en) begin
      if (borrow[DIGITS]) begin
        // Count is already zero: never wrap below zero, just stop.
        state_d = IDLE;
      end else if (count_dec == '0) begin
        done_d = 1'b1;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
        state_d = IDLE;
`endif
      end else begin
        count_d = count_dec;
      end
    end

    // zero tracks the value being registered so it is never a cycle stale.
    zero_d = (count_d == '0);
  end

  // State, count and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  // Reload register holding the most recent sanitised preset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign zero  = zero_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_down_counter
//  Description : Self-checking bench for bcd_down_counter (DIGITS=4) using an
//                integer-valued countdown reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_down_counter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        en;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        busy;
  logic        zero;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the count as a plain decimal integer.
  int m_cnt    = 0;
  bit m_busy   = 0;
  bit m_done   = 0;
  int m_reload = 0;

  bcd_down_counter #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .en       (en),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .zero     (zero),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal value of a preset after clamping each nibble to 9.
  function automatic int sanitize(input logic [15:0] lv);
    int v = 0;
    int p = 1;
    int d;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int rnd_load();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return int'(r[15:0]);
    return int'(r[4:0]);
  endfunction

  // Drive one clock cycle of inputs and advance the model across the edge.
  task automatic cycle(input logic s, input logic a, input logic e, input logic [15:0] lv);
    int n_cnt, n_rel, san;
    bit n_busy, n_done;
    start = s; abort = a; en = e; load_val = lv;
    n_cnt = m_cnt; n_busy = m_busy; n_done = 0; n_rel = m_reload;
    san = sanitize(lv);
    if (a) begin
      n_busy = 0;
    end else if (s) begin
      n_cnt = san;
      n_rel = san;
      n_busy = (san != 0);
      n_done = (san == 0);
    end else if (m_busy && e) begin
      if (m_cnt == 1) begin
        n_done = 1;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        n_cnt = m_reload;
`else
        n_cnt = 0;
        n_busy = 0;
`endif
      end else begin
        n_cnt = m_cnt - 1;
      end
    end
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_busy = n_busy; m_done = n_done; m_reload = n_rel;
    start = 0; abort = 0; en = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; abort = 0; en = 0; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (count !== 16'h0000 || busy !== 1'b0 || zero !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: count=%h busy=%b zero=%b done=%b, want 0000/0/1/0", count, busy, zero, done);
    end
    @(negedge clk);
    rst = 1'b1;
    m_cnt = 0; m_busy = 0; m_done = 0; m_reload = 0;
  endtask

  task automatic test_reset_mid_count();
    cycle(1, 0, 0, 16'h0050);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 16'h0000);
      n_cmp++;
      if (count !== to_bcd(m_cnt) || busy !== m_busy || zero !== (m_cnt == 0) || done !== m_done) begin
        n_err++;
        $display("FAIL reset_mid run%0d: count=%h busy=%b zero=%b done=%b, want %h/%b/%b/%b", i, count, busy, zero, done, to_bcd(m_cnt), m_busy, m_cnt == 0, m_done);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (count !== 16'h0000 || busy !== 1'b0 || zero !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid async: count=%h busy=%b zero=%b done=%b, want 0000/0/1/0", count, busy, zero, done);
    end
    m_cnt = 0; m_busy = 0; m_done = 0; m_reload = 0;
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 0, 1, 16'h0000);
    n_cmp++;
    if (count !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid after: count=%h busy=%b done=%b, want 0000/0/0", count, busy, done);
    end
  endtask

  task automatic test_borrow_chain();
    int dones = 0;
    cycle(1, 0, 0, 16'h1000);
    cycle(0, 0, 1, 16'h0000);
    n_cmp++;
    if (count !== 16'h0999 || busy !== 1'b1 || count !== to_bcd(m_cnt)) begin
      n_err++;
      $display("FAIL borrow_first: count=%h busy=%b, want 0999/1", count, busy);
    end
    for (int i = 0; i < 999; i++) begin
      cycle(0, 0, 1, 16'h0000);
      if (done === 1'b1) dones++;
      n_cmp++;
      if (count !== to_bcd(m_cnt) || busy !== m_busy || zero !== (m_cnt == 0) || done !== m_done) begin
        n_err++;
        $display("FAIL borrow_chain c%0d: count=%h busy=%b zero=%b done=%b, want %h/%b/%b/%b", i, count, busy, zero, done, to_bcd(m_cnt), m_busy, m_cnt == 0, m_done);
      end
    end
    n_cmp++;
    if (count !== 16'h0000 || done !== 1'b1 || busy !== 1'b0 || dones != 1) begin
      n_err++;
      $display("FAIL borrow_end: count=%h done=%b busy=%b pulses=%0d, want 0000/1/0/1", count, done, busy, dones);
    end
    cycle(0, 0, 1, 16'h0000);
    n_cmp++;
    if (done !== 1'b0 || count !== 16'h0000) begin
      n_err++;
      $display("FAIL borrow_done_drop: done=%b count=%h, want 0/0000", done, count);
    end
  endtask

  task automatic test_enable_saturation();
    int en_cycles = 0;
    int done_at = -1;
    cycle(1, 0, 0, 16'h00AF);
    n_cmp++;
    if (count !== 16'h0099 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL saturation: count=%h busy=%b, want 0099/1", count, busy);
    end
    for (int i = 0; i < 200; i++) begin
      logic e;
      e = (i % 2 == 0);
      cycle(0, 0, e, 16'h0000);
      if (e) en_cycles++;
      if (done === 1'b1 && done_at < 0) done_at = en_cycles;
      n_cmp++;
      if (count !== to_bcd(m_cnt) || busy !== m_busy || zero !== (m_cnt == 0) || done !== m_done) begin
        n_err++;
        $display("FAIL en_gating c%0d: count=%h busy=%b zero=%b done=%b, want %h/%b/%b/%b", i, count, busy, zero, done, to_bcd(m_cnt), m_busy, m_cnt == 0, m_done);
      end
    end
    n_cmp++;
    if (done_at != 99) begin
      n_err++;
      $display("FAIL en_done_cycle: done after %0d enabled cycles, want 99", done_at);
    end
  endtask

  task automatic test_priority();
    cycle(1, 0, 0, 16'h0020);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'h0000);
    n_cmp++;
    if (count !== 16'h0015 || count !== to_bcd(m_cnt)) begin
      n_err++;
      $display("FAIL prio_pre: count=%h, want 0015", count);
    end
    cycle(1, 1, 1, 16'h0042);
    n_cmp++;
    if (count !== 16'h0015 || busy !== 1'b0 || done !== 1'b0 || busy !== m_busy) begin
      n_err++;
      $display("FAIL prio_abort: count=%h busy=%b done=%b, want 0015/0/0", count, busy, done);
    end
    cycle(0, 0, 1, 16'h0000);
    n_cmp++;
    if (count !== 16'h0015 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL prio_idle_hold: count=%h busy=%b, want 0015/0", count, busy);
    end
    cycle(1, 0, 0, 16'h0020);
    cycle(0, 0, 1, 16'h0000);
    cycle(1, 0, 1, 16'h0003);
    n_cmp++;
    if (count !== 16'h0003 || busy !== 1'b1 || done !== 1'b0 || count !== to_bcd(m_cnt)) begin
      n_err++;
      $display("FAIL prio_restart: count=%h busy=%b done=%b, want 0003/1/0", count, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 16'h0000);
      n_cmp++;
      if (count !== to_bcd(m_cnt) || busy !== m_busy || zero !== (m_cnt == 0) || done !== m_done) begin
        n_err++;
        $display("FAIL prio_tail c%0d: count=%h busy=%b zero=%b done=%b, want %h/%b/%b/%b", i, count, busy, zero, done, to_bcd(m_cnt), m_busy, m_cnt == 0, m_done);
      end
    end
  endtask

  task automatic test_zero_load();
    cycle(1, 0, 0, 16'h0000);
    n_cmp++;
    if (done !== 1'b1 || zero !== 1'b1 || busy !== 1'b0 || count !== 16'h0000) begin
      n_err++;
      $display("FAIL zero_load: done=%b zero=%b busy=%b count=%h, want 1/1/0/0000", done, zero, busy, count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 16'h0000);
      n_cmp++;
      if (count !== 16'h0000 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
        n_err++;
        $display("FAIL zero_idle_en c%0d: count=%h done=%b busy=%b zero=%b, want 0000/0/0/1", i, count, done, busy, zero);
      end
    end
  endtask

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int exp_seq[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    cycle(1, 0, 0, 16'h0003);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 1, 16'h0000);
      n_cmp++;
      if (count !== to_bcd(exp_seq[i]) || busy !== 1'b1 || zero !== 1'b0 || done !== (exp_seq[i] == 3) || count !== to_bcd(m_cnt)) begin
        n_err++;
        $display("FAIL auto_reload c%0d: count=%h busy=%b zero=%b done=%b, want %h/1/0/%b", i, count, busy, zero, done, to_bcd(exp_seq[i]), exp_seq[i] == 3);
      end
    end
    cycle(0, 1, 0, 16'h0000);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic s, a, e;
      logic [15:0] lv;
      s = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 3) != 0);
      lv = 16'(rnd_load());
      if (!m_busy && !s && $urandom_range(0, 3) == 0) s = 1'b1;
      cycle(s, a, e, lv);
      n_cmp++;
      if (count !== to_bcd(m_cnt) || busy !== m_busy || zero !== (m_cnt == 0) || done !== m_done) begin
        n_err++;
        $display("FAIL random c%0d: count=%h busy=%b zero=%b done=%b, want %h/%b/%b/%b", i, count, busy, zero, done, to_bcd(m_cnt), m_busy, m_cnt == 0, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_borrow_chain();
    test_enable_saturation();
    test_priority();
    test_zero_load();
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
